// File: rtl/fp_pkg.sv
// Shared definitions for the FPU write-back staging queue.
//
// Contents:
//   FP_*               default widths for the FPU result path
//   FP_WB_STALL_MARGIN number of FPU beats that can still arrive after
//                      stall_issue rises (two pipeline stages in flight)
//   fp_wb_entry_t      one queued write-back record
//   fp_hart_idx        one-hot hart mask to hart index
package fp_pkg;

  localparam int FP_RV              = 64;
  localparam int FP_NHART           = 1;
  localparam int FP_LNHART          = 0;
  localparam int FP_HW              = (FP_LNHART > 0) ? FP_LNHART : 1;
  localparam int FP_NCOMMIT         = 32;
  localparam int FP_LNCOMMIT        = 5;
  localparam int FP_WB_STALL_MARGIN = 2;

  typedef struct packed {
    logic                   valid;
    logic [FP_RV-1:0]       data;
    logic [FP_LNCOMMIT-1:0] rd;
    logic                   fp;
    logic [FP_HW-1:0]       hart;
  } fp_wb_entry_t;

  // The FPU signals its hart as a one-hot mask; entries store an index.
  function automatic logic [FP_HW-1:0] fp_hart_idx(input logic [FP_NHART-1:0] oh);
    logic [FP_HW-1:0] idx;
    idx = '0;
    for (int i = 0; i < FP_NHART; i++) begin
      if (oh[i]) idx = FP_HW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fp_wb_queue.sv
// FPU write-back staging queue.
//
// Captures single-cycle FPU result beats and div/sqrt results into an
// in-order FIFO and offers one register-file write per cycle. Because the
// FPU cannot stall, the queue throttles issue early and flags a sticky
// overflow if a beat still arrives with no room. Results whose commit
// register is killed are never written, and stored entries are turned into
// bubbles when their commit register is killed later.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   fpu_result/_rd/_makes_fp   FPU result beat; fpu_res_makes_rd one-hot
//                              hart valid (0 = no beat)
//   div_valid/div_ready        div/sqrt handshake, with div_result/rd/hart
//   commit_kill                per-commit-register kill mask
//   wb_valid/wb_ready          register-file write handshake
//   wb_data/wb_rd/wb_fp        head entry fields, wb_makes_rd one-hot hart
//   stall_issue                FPU issue must hold
//   overflow                   sticky: an FPU beat was dropped
module fp_wb_queue
  import fp_pkg::*;
#(
  parameter int RV       = FP_RV,
  parameter int NHART    = FP_NHART,
  parameter int LNHART   = FP_LNHART,
  parameter int NCOMMIT  = FP_NCOMMIT,
  parameter int LNCOMMIT = FP_LNCOMMIT,
  parameter int DEPTH    = 4,
  localparam int HW      = (LNHART > 0) ? LNHART : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [RV-1:0]       fpu_result,
  input  logic [LNCOMMIT-1:0] fpu_res_rd,
  input  logic                fpu_res_makes_fp,
  input  logic [NHART-1:0]    fpu_res_makes_rd,
  input  logic                div_valid,
  output logic                div_ready,
  input  logic [RV-1:0]       div_result,
  input  logic [LNCOMMIT-1:0] div_rd,
  input  logic [HW-1:0]       div_hart,
  input  logic [NCOMMIT-1:0]  commit_kill,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [RV-1:0]       wb_data,
  output logic [LNCOMMIT-1:0] wb_rd,
  output logic                wb_fp,
  output logic [NHART-1:0]    wb_makes_rd,
  output logic                stall_issue,
  output logic                overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fp_wb_entry_t mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  fp_wb_entry_t  head;
  fp_wb_entry_t  fpu_entry;
  fp_wb_entry_t  div_entry;
  logic          head_valid;
  logic          pop;
  logic [CW-1:0] count_after_pop;
  logic          fpu_req;
  logic          fpu_push;
  logic          div_push;
  logic [AW-1:0] div_slot;
  logic [DEPTH-1:0] kill_hit;

  // Kill scan: every stored entry checks its own commit register each cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
    assign kill_hit[gi] = commit_kill[mem_q[gi].rd];
  end

  always_comb begin
    head            = mem_q[rd_ptr_q];
    head_valid      = (count_q != '0) && head.valid;
    // A killed bubble at the head leaves without using the write port.
    pop             = (count_q != '0) && (!head.valid || wb_ready);
    // The pop frees its slot before the FPU beat is checked for room.
    count_after_pop = count_q - CW'(pop);

    fpu_req  = (|fpu_res_makes_rd) && !commit_kill[fpu_res_rd];
    fpu_push = fpu_req && (count_after_pop != CW'(DEPTH));
    // div_ready leaves a slot for an FPU beat, so the div push always fits.
    div_push = div_valid && div_ready && !commit_kill[div_rd];
    div_slot = wr_ptr_q + AW'(fpu_push);

    fpu_entry.valid = 1'b1;
    fpu_entry.data  = fpu_result;
    fpu_entry.rd    = fpu_res_rd;
    fpu_entry.fp    = fpu_res_makes_fp;
    fpu_entry.hart  = fp_hart_idx(fpu_res_makes_rd);

    div_entry.valid = 1'b1;
    div_entry.data  = div_result;
    div_entry.rd    = div_rd;
    div_entry.fp    = 1'b1;
    div_entry.hart  = div_hart;

    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(fpu_push) + AW'(div_push);
    count_d    = count_after_pop + CW'(fpu_push) + CW'(div_push);
    overflow_d = overflow_q || (fpu_req && !fpu_push);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // A new write wins over kill/pop clears: when full with a pop, the FPU
  // beat lands in the slot the head is vacating.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset) begin
        mem_q[i].valid <= 1'b0;
      end else if (fpu_push && (wr_ptr_q == AW'(i))) begin
        mem_q[i] <= fpu_entry;
      end else if (div_push && (div_slot == AW'(i))) begin
        mem_q[i] <= div_entry;
      end else if (kill_hit[i] || (pop && (rd_ptr_q == AW'(i)))) begin
        mem_q[i].valid <= 1'b0;
      end
    end
  end

  assign wb_valid    = head_valid;
  assign wb_data     = head.data;
  assign wb_rd       = head.rd;
  assign wb_fp       = head.fp;
  assign wb_makes_rd = head_valid ? (NHART'(1) << head.hart) : '0;
  assign stall_issue = count_q >= CW'(DEPTH - FP_WB_STALL_MARGIN);
  assign div_ready   = (CW'(DEPTH) - count_q) >= CW'(FP_WB_STALL_MARGIN);
  assign overflow    = overflow_q;

  // The occupancy can never exceed the storage, even when a beat is dropped.
  a_count_bound : assert property (@(posedge clk) disable iff (!reset)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_fp_wb_queue.sv
module tb_fp_wb_queue;

  localparam int DEPTH = 4;
  localparam logic [63:0] DBASE = 64'h3FF0_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] fpu_result;
  logic [4:0]  fpu_res_rd;
  logic        fpu_res_makes_fp;
  logic [0:0]  fpu_res_makes_rd;
  logic        div_valid;
  logic        div_ready;
  logic [63:0] div_result;
  logic [4:0]  div_rd;
  logic [0:0]  div_hart;
  logic [31:0] commit_kill;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_fp;
  logic [0:0]  wb_makes_rd;
  logic        stall_issue;
  logic        overflow;

  always #5 clk = ~clk;

  fp_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .fpu_result(fpu_result), .fpu_res_rd(fpu_res_rd),
    .fpu_res_makes_fp(fpu_res_makes_fp), .fpu_res_makes_rd(fpu_res_makes_rd),
    .div_valid(div_valid), .div_ready(div_ready), .div_result(div_result),
    .div_rd(div_rd), .div_hart(div_hart), .commit_kill(commit_kill),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_fp(wb_fp), .wb_makes_rd(wb_makes_rd),
    .stall_issue(stall_issue), .overflow(overflow)
  );

  // Reference model: an ordinary queue of pending writes.
  typedef struct {
    bit          valid;
    logic [63:0] data;
    logic [4:0]  rd;
    bit          fp;
  } ent_t;

  ent_t m_q[$];
  bit   m_ovf;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs now on the pins.
  task automatic model_step();
    bit   can_div;
    ent_t e;
    if (!reset) begin
      m_q.delete();
      m_ovf = 0;
      return;
    end
    can_div = (DEPTH - m_q.size()) >= 2;
    if (m_q.size() > 0 && (!m_q[0].valid || wb_ready)) void'(m_q.pop_front());
    foreach (m_q[i]) if (commit_kill[m_q[i].rd]) m_q[i].valid = 0;
    if (fpu_res_makes_rd != 0 && !commit_kill[fpu_res_rd]) begin
      if (m_q.size() < DEPTH) begin
        e = '{1, fpu_result, fpu_res_rd, fpu_res_makes_fp};
        m_q.push_back(e);
      end else begin
        m_ovf = 1;
      end
    end
    if (div_valid && can_div && !commit_kill[div_rd]) begin
      e = '{1, div_result, div_rd, 1'b1};
      m_q.push_back(e);
    end
  endtask

  task automatic check_model();
    bit ev;
    ev = (m_q.size() > 0) && m_q[0].valid;
    chk("m_wb_valid", wb_valid, ev);
    chk("m_makes_rd", wb_makes_rd, ev);
    if (ev) begin
      chk("m_wb_rd", wb_rd, m_q[0].rd);
      chk("m_wb_data", wb_data, m_q[0].data);
      chk("m_wb_fp", wb_fp, m_q[0].fp);
    end
    chk("m_stall", stall_issue, m_q.size() >= DEPTH - 2);
    chk("m_div_ready", div_ready, (DEPTH - m_q.size()) >= 2);
    chk("m_overflow", overflow, m_ovf);
  endtask

  task automatic cycle();
    if (reset && wb_valid && wb_ready)
      $display("wb  rd=%0d fp=%0b data=%h", wb_rd, wb_fp, wb_data);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(bit rst_n, bit fv, logic [4:0] frd, bit dv,
                       logic [4:0] drd, int kbit, bit wbr);
    reset            = rst_n;
    fpu_res_makes_rd = fv;
    fpu_res_rd       = frd;
    fpu_result       = DBASE + 64'(frd);
    fpu_res_makes_fp = frd[0];
    div_valid        = dv;
    div_rd           = drd;
    div_result       = DBASE + 64'(drd);
    div_hart         = 1'b0;
    commit_kill      = (kbit >= 0) ? (32'h1 << kbit) : 32'h0;
    wb_ready         = wbr;
  endtask

  typedef struct {
    bit rst_n; bit fv; logic [4:0] frd; bit dv; logic [4:0] drd; int kbit; bit wbr;
    bit e_valid; logic [4:0] e_rd; bit e_stall; bit e_dr; bit e_ovf;
  } vec_t;

  vec_t vt[$];

  initial begin
    drive(0, 0, 0, 0, 0, -1, 0);
    @(negedge clk);

    //        rst fv frd dv drd kill wbr | vld rd stl dr ovf
    vt.push_back('{0, 0,  0, 0, 0, -1, 0,   0,  0, 0, 1, 0});
    vt.push_back('{1, 1,  5, 0, 0, -1, 1,   1,  5, 0, 1, 0});
    vt.push_back('{1, 0,  0, 0, 0, -1, 1,   0,  0, 0, 1, 0});
    vt.push_back('{1, 1,  1, 0, 0, -1, 0,   1,  1, 0, 1, 0});
    vt.push_back('{1, 1,  2, 0, 0, -1, 0,   1,  1, 1, 1, 0});
    vt.push_back('{1, 1,  3, 0, 0, -1, 0,   1,  1, 1, 0, 0});
    vt.push_back('{1, 0,  0, 0, 0, -1, 1,   1,  2, 1, 1, 0});
    vt.push_back('{1, 0,  0, 0, 0, -1, 1,   1,  3, 0, 1, 0});
    vt.push_back('{1, 0,  0, 0, 0, -1, 1,   0,  0, 0, 1, 0});
    vt.push_back('{1, 1,  3, 1, 7, -1, 1,   1,  3, 1, 1, 0});
    vt.push_back('{1, 0,  0, 0, 0, -1, 1,   1,  7, 0, 1, 0});
    vt.push_back('{1, 0,  0, 0, 0, -1, 1,   0,  0, 0, 1, 0});
    vt.push_back('{1, 1,  9, 0, 0,  9, 0,   0,  0, 0, 1, 0});
    vt.push_back('{1, 1,  2, 0, 0, -1, 0,   1,  2, 0, 1, 0});
    vt.push_back('{1, 1,  4, 0, 0, -1, 0,   1,  2, 1, 1, 0});
    vt.push_back('{1, 1,  6, 0, 0, -1, 0,   1,  2, 1, 0, 0});
    vt.push_back('{1, 0,  0, 1, 8,  4, 0,   1,  2, 1, 0, 0});
    vt.push_back('{1, 0,  0, 0, 0, -1, 1,   0,  0, 1, 1, 0});
    vt.push_back('{1, 0,  0, 0, 0, -1, 0,   1,  6, 0, 1, 0});
    vt.push_back('{1, 0,  0, 0, 0, -1, 1,   0,  0, 0, 1, 0});
    vt.push_back('{1, 1, 10, 0, 0, -1, 0,   1, 10, 0, 1, 0});
    vt.push_back('{1, 1, 11, 0, 0, -1, 0,   1, 10, 1, 1, 0});
    vt.push_back('{1, 1, 12, 0, 0, -1, 0,   1, 10, 1, 0, 0});
    vt.push_back('{1, 1, 13, 0, 0, -1, 0,   1, 10, 1, 0, 0});
    vt.push_back('{1, 1, 14, 0, 0, -1, 1,   1, 11, 1, 0, 0});
    vt.push_back('{1, 1, 15, 0, 0, -1, 0,   1, 11, 1, 0, 1});
    vt.push_back('{1, 0,  0, 0, 0, -1, 0,   1, 11, 1, 0, 1});
    vt.push_back('{0, 0,  0, 0, 0, -1, 0,   0,  0, 0, 1, 0});
    vt.push_back('{1, 0,  0, 0, 0, -1, 1,   0,  0, 0, 1, 0});

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst_n, vt[i].fv, vt[i].frd, vt[i].dv, vt[i].drd, vt[i].kbit, vt[i].wbr);
      cycle();
      $display("vec %0d: wb_valid=%0b rd=%0d stall=%0b div_ready=%0b ovf=%0b",
               i, wb_valid, wb_rd, stall_issue, div_ready, overflow);
      chk($sformatf("tv%0d_valid", i), wb_valid, vt[i].e_valid);
      chk($sformatf("tv%0d_makes_rd", i), wb_makes_rd, vt[i].e_valid);
      if (vt[i].e_valid) begin
        chk($sformatf("tv%0d_rd", i), wb_rd, vt[i].e_rd);
        chk($sformatf("tv%0d_data", i), wb_data, DBASE + 64'(vt[i].e_rd));
        chk($sformatf("tv%0d_fp", i), wb_fp, vt[i].e_rd[0]);
      end
      chk($sformatf("tv%0d_stall", i), stall_issue, vt[i].e_stall);
      chk($sformatf("tv%0d_div_ready", i), div_ready, vt[i].e_dr);
      chk($sformatf("tv%0d_overflow", i), overflow, vt[i].e_ovf);
    end

    // Two paired FPU+div pushes fill the queue; drain must keep FPU-first order.
    begin
      logic [4:0] order [4] = '{5'd20, 5'd21, 5'd22, 5'd23};
      drive(1, 1, 20, 1, 21, -1, 0); cycle();
      drive(1, 1, 22, 1, 23, -1, 0); cycle();
      $display("pair fill: head rd=%0d stall=%0b div_ready=%0b", wb_rd, stall_issue, div_ready);
      chk("pair_full_stall", stall_issue, 1'b1);
      chk("pair_full_div_ready", div_ready, 1'b0);
      chk("pair_head0", wb_rd, order[0]);
      for (int k = 1; k < 4; k++) begin
        drive(1, 0, 0, 0, 0, -1, 1); cycle();
        $display("pair drain %0d: rd=%0d", k, wb_rd);
        chk($sformatf("pair_head%0d", k), wb_rd, order[k]);
      end
      drive(1, 0, 0, 0, 0, -1, 1); cycle();
      chk("pair_empty", wb_valid, 1'b0);
    end

    // Randomised traffic against the queue model.
    for (int seg = 0; seg < 6; seg++) begin
      drive(0, 0, 0, 0, 0, -1, 0); cycle(); cycle();
      for (int c = 0; c < 200; c++) begin
        bit fv;
        fv = ($urandom_range(3) != 0) && ((m_q.size() < DEPTH - 2) || ($urandom_range(15) == 0));
        drive(($urandom_range(199) != 0), fv, 5'($urandom_range(15)),
              ($urandom_range(2) == 0), 5'($urandom_range(15)),
              ($urandom_range(5) == 0) ? int'($urandom_range(15)) : -1,
              ($urandom_range(2) != 0));
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
